// File: rtl/tick_gen_pkg.sv
// Shared types and elaboration helpers for the multi-channel tick generator.
// Divisors are carried at a fixed 64-bit width; upper bits beyond CNT_W stay zero.
package tick_gen_pkg;

  localparam int MIN_DIV = 2;
  localparam int DIV_W   = 64;

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic             en;
    logic             oneshot;
  } ch_cfg_t;

  function automatic logic [DIV_W-1:0] def_div(input longint unsigned sys_f,
                                               input longint unsigned f);
    return (f == 0) ? DIV_W'(MIN_DIV) : DIV_W'(sys_f / f);
  endfunction

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : d;
  endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// One tick channel: down-counter, active/shadow config, registered tick and level.
// The shadow commits at the next wrap or sync; restart writes and writes to an idle channel commit at once.
module tick_gen_ch
  import tick_gen_pkg::*;
#(
  parameter int               CNT_W   = 32,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(1000)
) (
  input  logic    sys_clk,
  input  logic    rst_n,
  input  logic    i_wr,
  input  logic    i_restart,
  input  logic    i_sync,
  input  ch_cfg_t i_cfg,
  output logic    o_tick,
  output logic    o_clk_lvl,
  output logic    o_busy,
  output logic    o_pending
);

  localparam ch_cfg_t RST_CFG = '{div: DIV_W'(DEF_DIV), en: 1'b1, oneshot: 1'b0};

  ch_cfg_t          r_act;
  ch_cfg_t          r_shd;
  logic             r_pending;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             r_clk_lvl;

  logic             w_wrap;
  logic             w_now;
  logic             w_defer;
  logic             w_lvl;
  logic [DIV_W-1:0] w_half;
  ch_cfg_t          w_next;
  ch_cfg_t          w_wrap_cfg;

  always_comb begin
    w_wrap     = r_act.en && (r_cnt == '0);
    w_now      = i_wr && (i_restart || !r_act.en);
    w_defer    = i_wr && !w_now;
    w_half     = (r_act.div - DIV_W'(1)) >> 1;
    w_lvl      = r_act.en && (DIV_W'(r_cnt) > w_half);
    w_next     = r_pending ? r_shd : r_act;
    // A one-shot wrap disables the channel unless a fresh shadow takes over.
    w_wrap_cfg = w_next;
    if (!r_pending && r_act.oneshot) w_wrap_cfg.en = 1'b0;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act     <= RST_CFG;
      r_shd     <= RST_CFG;
      r_pending <= 1'b0;
      r_cnt     <= DEF_DIV - CNT_W'(1);
      r_tick    <= 1'b0;
      r_clk_lvl <= 1'b0;
    end else begin
      r_tick    <= 1'b0;
      r_clk_lvl <= w_lvl;
      if (w_now) begin
        r_act     <= i_cfg;
        r_cnt     <= CNT_W'(i_cfg.div - DIV_W'(1));
        r_pending <= 1'b0;
      end else if (r_act.en && (i_sync || w_wrap)) begin
        r_tick    <= w_wrap && !i_sync;
        r_act     <= i_sync ? w_next : w_wrap_cfg;
        r_cnt     <= CNT_W'(w_next.div - DIV_W'(1));
        r_pending <= w_defer;
        if (w_defer) r_shd <= i_cfg;
      end else if (r_act.en) begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (w_defer) begin
          r_shd     <= i_cfg;
          r_pending <= 1'b1;
        end
      end else if (r_pending) begin
        // Shadow left behind by a one-shot wrap: apply it without a tick.
        r_act     <= r_shd;
        r_cnt     <= CNT_W'(r_shd.div - DIV_W'(1));
        r_pending <= 1'b0;
      end
    end
  end

  assign o_tick    = r_tick;
  assign o_clk_lvl = r_clk_lvl;
  assign o_busy    = r_act.en | r_pending;
  assign o_pending = r_pending;

endmodule

// File: rtl/multi_tick_gen.sv
// Multi-channel programmable tick generator: config decode, cfg_ready mux and sync fan-out.
// Config handshake: a transfer happens on a rising edge where cfg_valid & cfg_ready; cfg_ready depends only on cfg_ch and registered pending state.
module multi_tick_gen
  import tick_gen_pkg::*;
#(
  parameter int  NUM_CH       = 4,
  parameter int  CNT_W        = 32,
  parameter int  SYS_CLK_FREQ = 100_000_000,
  parameter int  DEFAULT_FREQ = 100_000,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_en,
  input  logic              cfg_oneshot,
  input  logic              cfg_restart,
  input  logic              sync_start,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_lvl,
  output logic [NUM_CH-1:0] busy
);

  localparam logic [CNT_W-1:0] DEF_DIV =
    CNT_W'(clamp_div(def_div(64'(SYS_CLK_FREQ), 64'(DEFAULT_FREQ))));

  logic [NUM_CH-1:0] w_pending;
  logic [NUM_CH-1:0] w_wr;
  logic              w_xfer;
  logic              w_ch_ok;
  ch_cfg_t           w_cfg;

  always_comb begin
    w_ch_ok       = (32'(cfg_ch) < NUM_CH);
    cfg_ready     = w_ch_ok ? !w_pending[cfg_ch] : 1'b1;
    w_xfer        = cfg_valid && cfg_ready;
    w_cfg.div     = clamp_div(DIV_W'(cfg_div));
    w_cfg.en      = cfg_en;
    w_cfg.oneshot = cfg_oneshot;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_wr[g] = w_xfer && (cfg_ch == CH_W'(g));

    tick_gen_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .i_wr      (w_wr[g]),
      .i_restart (cfg_restart),
      .i_sync    (sync_start),
      .i_cfg     (w_cfg),
      .o_tick    (tick[g]),
      .o_clk_lvl (clk_lvl[g]),
      .o_busy    (busy[g]),
      .o_pending (w_pending[g])
    );
  end

endmodule

// File: doc/multi_tick_gen.md
# multi_tick_gen

Multi-channel programmable tick generator deriving single-cycle enable pulses and square-wave levels from `sys_clk`. Each channel's period is set at runtime through a valid/ready config port. Changes apply glitch-free at the channel's next wrap or immediately on request. Periodic and one-shot modes are supported, as is a global phase-align strobe. It sits beside the top-level clocking and feeds slow-rate enables to scanners, debouncers and UART/I2C bit timers.

## Interface
- `NUM_CH`, default 4: number of independent channels (1..16).
- `CNT_W`, default 32: counter/divisor width.
- `SYS_CLK_FREQ`, default 100_000_000: `sys_clk` frequency, in Hz.
- `DEFAULT_FREQ`, default 100_000: reset tick rate, in Hz.
  - Gives `DEF_DIV = SYS_CLK_FREQ/DEFAULT_FREQ`.
- `sys_clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `cfg_valid`, in, 1: config request.
- `cfg_ready`, out, 1: config accept. Transfer occurs when `cfg_valid & cfg_ready`.
- `cfg_ch`, in, `$clog2(NUM_CH)` (min 1): target channel.
- `cfg_div`, in, `CNT_W`: period in `sys_clk` cycles.
- `cfg_en`, in, 1: channel enable.
- `cfg_oneshot`, in, 1: 1 = one-shot, 0 = periodic.
- `cfg_restart`, in, 1: apply immediately and reload the counter.
- `sync_start`, in, 1: single-cycle strobe; realigns all enabled channels.
- `tick`, out, `NUM_CH`: per-channel single-cycle pulse, registered.
- `clk_lvl`, out, `NUM_CH`: per-channel ~50% duty level, registered.
- `busy`, out, `NUM_CH`: channel enabled, or a shadow update is pending.

## Operation
- **Per-channel state:**
  - `div` (active period), `cnt` (down-counter), `en`, `oneshot`.
  - Shadow `{div, en, oneshot}` plus a `pending` flag.
- **Reset values:**
  - `div=DEF_DIV`, `cnt=DEF_DIV-1`, `en=1`, `oneshot=0`, `pending=0`.
  - Outputs: `tick=0`, `clk_lvl=0`, `busy=all 1s`, `cfg_ready=1`.
- **Divisor clamp:** `cfg_div<2` is stored as 2. Arithmetic is unsigned `CNT_W`. `half = (div-1)>>1`.
- **Counting (en=1):**
  - If `cnt!=0`, then `cnt<=cnt-1`.
  - If `cnt==0` (wrap), then `cnt<=div-1` and `tick` is high the following cycle.
  - `clk_lvl <= (cnt > half)`.
- **Disabled (en=0):** `cnt` holds, `tick=0`, `clk_lvl=0`.
- **Config accept without `cfg_restart`, channel enabled:**
  - Writes the shadow and sets `pending`.
  - At the channel's next wrap, the shadow is committed. The reload uses the new `div-1`, and `pending` clears.
- **Config accept with `cfg_restart`, or target channel disabled:**
  - Commits in the same cycle, with `cnt<=new_div-1`.
  - No tick results from that cycle.
- **`cfg_ready`:** equals `~pending[cfg_ch]`. A second write to a channel with an uncommitted update stalls until that channel's wrap.
- **One-shot:** on the wrap that produces the tick, `en` clears. The channel then stays idle until reconfigured.
- **`sync_start`:**
  - Every enabled channel commits any pending shadow and loads `cnt<=div-1`.
  - No channel ticks from that cycle.
- **Simultaneous events:**
  - A restart config to channel c in the same cycle as `sync_start`: the config wins for c.
  - A wrap coinciding with an accepted non-restart config: the old shadow, if any, commits. The new write is refused because `cfg_ready=0`.
  - If no shadow was pending, the write lands in the shadow and commits at the following wrap.
- **Reset mid-operation:** all state returns to reset values immediately, regardless of `cfg_valid`.

## Timing
- Edge 1 is the first `sys_clk` rising edge after `rst_n` deasserts.
- After reset, channel c's first tick is high during the cycle after edge `DEF_DIV`. Ticks then repeat every `div` cycles.
- `tick` latency from `cnt==0` is exactly 1 cycle. `clk_lvl` lags `cnt` by 1 cycle.
- A restart config accepted at edge k with divisor D produces the first tick after edge k+D. `sync_start` follows the same rule.
- `cfg_ready` is combinational from `cfg_ch` and registered `pending`. There is no combinational path from `cfg_valid`.

## Structure
- **Package `tick_gen_pkg`:**
  - `function def_div(sys_f, f)`.
  - `function clamp_div`.
  - Localparam minimum divisor, `MIN_DIV=2`.
  - Typedef `ch_cfg_t {div, en, oneshot}`.
- **Sub-module `tick_gen_ch`:** one channel, instantiated `NUM_CH` times via generate. It holds `cnt`, active/shadow config, `pending`, `tick` and `clk_lvl`.
- **Top level:** contains only the config decode, `cfg_ready` mux and `sync_start` fan-out.

## Test plan
- **Reset default:** `DEF_DIV=1000`, no config. `tick[0]` goes high during the cycle after edge 1000, then after edges 2000 and 3000. `clk_lvl[0]` is high for 500 of every 1000 cycles.
- **Deferred update:** ch1 is running with div=10. A non-restart write of div=4 is made at cnt=6. The remaining ticks keep the 10-cycle spacing up to the wrap, then the spacing becomes 4. `cfg_ready` is low for ch1 until that wrap. A second write is held off.
- **Restart and clamp:** a restart write to ch2 with div=1 at edge k. The stored divisor is 2. Ticks occur after edges k+2, k+4, and so on.
- **One-shot:** ch3 is written with oneshot=1, div=5, restart at edge k. Exactly one tick occurs, after edge k+5. `busy[3]` then drops to 0 and no further ticks occur.
- **`sync_start` alignment:** ch0/ch1 are running with div=8/12 at arbitrary phase. After `sync_start` at edge k, they tick after edges k+8 and k+12, respectively. A restart write to ch1 with div=3 in the same cycle instead makes ch1 tick after edge k+3.
- **Async reset mid-count:** assert `rst_n=0` between edges. `tick`/`clk_lvl` drop immediately and `pending` clears. After release, the reset-default schedule repeats.
